// File: rtl/station_access_arbiter.sv
// station_access_arbiter
// Once per frame, turns both players' chop/carry buttons into read-modify-write
// operations on the shared single-port kitchen tile RAM. The two players are
// served one after the other with round-robin priority. The block also tracks
// the item each player carries and each player's chop-progress counter.
//
// Ports:
//   clk_in, reset        system clock, synchronous active-high reset
//   frame_tick           one-cycle pulse per frame; sampled only while idle
//   pN_x, pN_y, pN_dir   player position (pixels) and facing (0 L,1 R,2 U,3 D)
//   pN_chop, pN_carry    button levels
//   mem_addr/we/wdata    tile RAM port (addr = row*TILE_COLS + col)
//   mem_rdata            tile RAM data, MEM_LATENCY cycles after mem_addr
//   pN_held              carried item code (0 = empty hands)
//   pN_chop_prog         frames of chop accumulated on the current raw tile
//   busy                 an access sequence is in progress
module station_access_arbiter #(
  parameter int ARENA_X0    = 144,
  parameter int ARENA_Y0    = 144,
  parameter int TILE_COLS   = 10,
  parameter int TILE_ROWS   = 5,
  parameter int CHOP_FRAMES = 30,
  parameter int MEM_LATENCY = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [8:0] p0_x,
  input  logic [8:0] p1_x,
  input  logic [8:0] p0_y,
  input  logic [8:0] p1_y,
  input  logic [1:0] p0_dir,
  input  logic [1:0] p1_dir,
  input  logic       p0_chop,
  input  logic       p1_chop,
  input  logic       p0_carry,
  input  logic       p1_carry,
  output logic [5:0] mem_addr,
  output logic       mem_we,
  output logic [3:0] mem_wdata,
  input  logic [3:0] mem_rdata,
  output logic [3:0] p0_held,
  output logic [3:0] p1_held,
  output logic [5:0] p0_chop_prog,
  output logic [5:0] p1_chop_prog,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EXEC, S_WR, S_NEXT} state_t;

  localparam logic signed [11:0] OFF_X  = 12'(16 - ARENA_X0);
  localparam logic signed [11:0] OFF_Y  = 12'(16 - ARENA_Y0);
  localparam logic signed [11:0] COLS_S = 12'(TILE_COLS);
  localparam logic signed [11:0] ROWS_S = 12'(TILE_ROWS);
  localparam int                 CW     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(MEM_LATENCY - 1);

  logic [1:0][8:0] px, py;
  logic [1:0][1:0] pdir;
  logic [1:0]      chop_in, carry_in;
  logic [1:0]      face_ok;
  logic [1:0][5:0] face_addr;

  assign px       = {p1_x, p0_x};
  assign py       = {p1_y, p0_y};
  assign pdir     = {p1_dir, p0_dir};
  assign chop_in  = {p1_chop, p0_chop};
  assign carry_in = {p1_carry, p0_carry};

  // Facing tile per player. Arithmetic is signed so that players left of or
  // above the arena origin land on negative tiles and are rejected.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_face
      logic signed [11:0] col, row, fcol, frow;
      assign col = ($signed({3'b000, px[gi]}) + OFF_X) >>> 5;
      assign row = ($signed({3'b000, py[gi]}) + OFF_Y) >>> 5;
      always_comb begin
        fcol = col;
        frow = row;
        case (pdir[gi])
          2'd0:    fcol = col - 12'sd1;
          2'd1:    fcol = col + 12'sd1;
          2'd2:    frow = row - 12'sd1;
          default: frow = row + 12'sd1;
        endcase
      end
      assign face_ok[gi]   = (fcol >= 12'sd0) && (fcol < COLS_S) &&
                             (frow >= 12'sd0) && (frow < ROWS_S);
      assign face_addr[gi] = 6'(frow[5:0] * 6'(TILE_COLS)) + fcol[5:0];
    end
  endgenerate

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cur_q, cur_d;         // player currently being served
  logic            pending_q, pending_d; // other player still to be served
  logic            ptr_q, ptr_d;         // round-robin priority pointer
  logic [1:0]      carry_prev_q, carry_prev_d;
  logic [1:0]      carry_edge_q, carry_edge_d;
  logic [1:0][5:0] addr_q, addr_d;
  logic [1:0][3:0] held_q, held_d;
  logic [1:0][5:0] prog_q, prog_d;
  logic [1:0][5:0] chop_addr_q, chop_addr_d;
  logic [5:0]      mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_wdata_q, mem_wdata_d;

  logic [1:0] cedge_c, req_c;
  logic       first_c;
  logic [5:0] prog_n;
  logic [3:0] tile_c;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    pending_d    = pending_q;
    ptr_d        = ptr_q;
    carry_prev_d = carry_prev_q;
    carry_edge_d = carry_edge_q;
    addr_d       = addr_q;
    held_d       = held_q;
    prog_d       = prog_q;
    chop_addr_d  = chop_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    cedge_c      = carry_in & ~carry_prev_q;
    req_c        = face_ok & (cedge_c | chop_in);
    first_c      = (req_c == 2'b11) ? ptr_q : req_c[1];
    prog_n       = '0;
    tile_c       = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          carry_prev_d = carry_in;
          carry_edge_d = cedge_c;
          addr_d       = face_addr;
          // A player without a request has either released chop or faces
          // outside the arena; either way its chop run is broken.
          for (int i = 0; i < 2; i++) begin
            if (!req_c[i]) prog_d[i] = '0;
          end
          if (req_c != 2'b00) begin
            cur_d      = first_c;
            pending_d  = (req_c == 2'b11);
            if (req_c == 2'b11) ptr_d = ~ptr_q;
            mem_addr_d = face_addr[first_c];
            cnt_d      = '0;
            state_d    = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) state_d = S_EXEC;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_EXEC: begin
        if (carry_edge_q[cur_q]) begin
          prog_d[cur_q] = '0;
          if (held_q[cur_q] == 4'd0 && tile_c != 4'd0 && tile_c <= 4'd7) begin
            held_d[cur_q] = tile_c;
            mem_we_d      = 1'b1;
            mem_wdata_d   = 4'd0;
          end else if (held_q[cur_q] != 4'd0 && tile_c == 4'd0) begin
            held_d[cur_q] = 4'd0;
            mem_we_d      = 1'b1;
            mem_wdata_d   = held_q[cur_q];
          end
        end else if (tile_c == 4'd1 && held_q[cur_q] == 4'd0) begin
          // A nonzero count means the previous frame chopped; it only
          // continues if that chop was on this same tile.
          prog_n = (prog_q[cur_q] != '0 && chop_addr_q[cur_q] == addr_q[cur_q])
                   ? prog_q[cur_q] + 6'd1 : 6'd1;
          chop_addr_d[cur_q] = addr_q[cur_q];
          if (prog_n == 6'(CHOP_FRAMES)) begin
            prog_d[cur_q] = '0;
            mem_we_d      = 1'b1;
            mem_wdata_d   = 4'd2;
          end else begin
            prog_d[cur_q] = prog_n;
          end
        end else begin
          prog_d[cur_q] = '0;
        end
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (pending_q) begin
          pending_d  = 1'b0;
          cur_d      = ~cur_q;
          mem_addr_d = addr_q[~cur_q];
          cnt_d      = '0;
          state_d    = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_q        <= 1'b0;
      pending_q    <= 1'b0;
      ptr_q        <= 1'b0;
      carry_prev_q <= '0;
      carry_edge_q <= '0;
      addr_q       <= '0;
      held_q       <= '0;
      prog_q       <= '0;
      chop_addr_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      carry_prev_q <= carry_prev_d;
      carry_edge_q <= carry_edge_d;
      addr_q       <= addr_d;
      held_q       <= held_d;
      prog_q       <= prog_d;
      chop_addr_q  <= chop_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign p0_held      = held_q[0];
  assign p1_held      = held_q[1];
  assign p0_chop_prog = prog_q[0];
  assign p1_chop_prog = prog_q[1];
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_station_access_arbiter.sv
// Testbench for station_access_arbiter: a 2-cycle-latency tile RAM model
// driven by the DUT, plus a frame-level reference model of the kitchen
// (tile array, held items, chop counters, round-robin pointer).
module tb_station_access_arbiter;

  logic       clk_in = 1'b0;
  logic       reset, frame_tick;
  logic [8:0] t_x [2];
  logic [8:0] t_y [2];
  logic [1:0] t_dir [2];
  logic       t_chop [2];
  logic       t_carry [2];
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata, mem_rdata;
  logic [3:0] p0_held, p1_held;
  logic [5:0] p0_chop_prog, p1_chop_prog;
  logic       busy;

  station_access_arbiter dut (
    .clk_in(clk_in), .reset(reset), .frame_tick(frame_tick),
    .p0_x(t_x[0]), .p1_x(t_x[1]), .p0_y(t_y[0]), .p1_y(t_y[1]),
    .p0_dir(t_dir[0]), .p1_dir(t_dir[1]),
    .p0_chop(t_chop[0]), .p1_chop(t_chop[1]),
    .p0_carry(t_carry[0]), .p1_carry(t_carry[1]),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .p0_held(p0_held), .p1_held(p1_held),
    .p0_chop_prog(p0_chop_prog), .p1_chop_prog(p1_chop_prog),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Tile RAM: two-stage read pipeline, writes from the DUT or from pokes.
  logic [3:0] ram [64];
  logic [3:0] rd1, rd2;
  logic       poke_en = 1'b0;
  logic [5:0] poke_addr = '0;
  logic [3:0] poke_data = '0;
  int         wr_count = 0;

  always @(posedge clk_in) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
    rd1 <= ram[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_tiles [64];
  int m_held [2];
  int m_prog [2];
  int m_last [2];
  int m_cprev [2];
  int m_ptr;
  int m_writes;

  function automatic int facing(input int x, input int y, input int d);
    int c, r;
    c = (x + 16 - 144) >>> 5;
    r = (y + 16 - 144) >>> 5;
    if (d == 0) c = c - 1;
    else if (d == 1) c = c + 1;
    else if (d == 2) r = r - 1;
    else r = r + 1;
    if (c < 0 || c > 9 || r < 0 || r > 4) return -1;
    return r * 10 + c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 0; m_prog[i] = 0; m_last[i] = 0; m_cprev[i] = 0;
    end
    m_ptr = 0;
  endtask

  // One frame of kitchen behaviour using the current button/position inputs.
  task automatic model_frame();
    int a [2];
    bit ce [2];
    bit rq [2];
    int order [2];
    int ns;
    for (int i = 0; i < 2; i++) begin
      ce[i] = t_carry[i] && (m_cprev[i] == 0);
      m_cprev[i] = int'(t_carry[i]);
      a[i] = facing(int'(t_x[i]), int'(t_y[i]), int'(t_dir[i]));
      rq[i] = (a[i] >= 0) && (ce[i] || t_chop[i]);
      if (!rq[i]) m_prog[i] = 0;
    end
    m_writes = 0;
    ns = 0;
    if (rq[0] && rq[1]) begin
      order[0] = m_ptr; order[1] = 1 - m_ptr; ns = 2; m_ptr = 1 - m_ptr;
    end else if (rq[0]) begin
      order[0] = 0; ns = 1;
    end else if (rq[1]) begin
      order[0] = 1; ns = 1;
    end
    for (int k = 0; k < ns; k++) begin
      int i, t, p;
      i = order[k];
      t = m_tiles[a[i]];
      if (ce[i]) begin
        m_prog[i] = 0;
        if (m_held[i] == 0 && t >= 1 && t <= 7) begin
          m_held[i] = t; m_tiles[a[i]] = 0; m_writes++;
        end else if (m_held[i] != 0 && t == 0) begin
          m_tiles[a[i]] = m_held[i]; m_held[i] = 0; m_writes++;
        end
      end else if (t == 1 && m_held[i] == 0) begin
        p = (m_prog[i] > 0 && m_last[i] == a[i]) ? m_prog[i] + 1 : 1;
        m_last[i] = a[i];
        if (p == 30) begin
          m_tiles[a[i]] = 2; m_writes++; p = 0;
        end
        m_prog[i] = p;
      end else begin
        m_prog[i] = 0;
      end
    end
  endtask

  task automatic poke(input int a, input int d);
    @(negedge clk_in);
    poke_en = 1'b1; poke_addr = 6'(a); poke_data = 4'(d);
    @(negedge clk_in);
    poke_en = 1'b0;
    m_tiles[a] = d;
  endtask

  task automatic set_p(input int i, input int x, input int y, input int d,
                       input int ch, input int ca);
    t_x[i] = 9'(x); t_y[i] = 9'(y); t_dir[i] = 2'(d);
    t_chop[i] = (ch != 0); t_carry[i] = (ca != 0);
  endtask

  // Issue one frame tick, advance the model, wait (bounded) for idle.
  task automatic run_frame(output int writes);
    int start, n;
    start = wr_count;
    @(negedge clk_in);
    frame_tick = 1'b1;
    model_frame();
    @(negedge clk_in);
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    n_checks++;
    if (busy) $display("FAIL frame_idle_timeout: busy=%0d after %0d cycles, required 0", busy, n);
    else n_pass++;
    @(negedge clk_in);
    writes = wr_count - start;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0;
    for (int i = 0; i < 2; i++) set_p(i, 400, 300, 0, 0, 0);
    for (int a = 0; a < 64; a++) poke(a, 0);
    model_reset();
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({mem_addr, mem_we, mem_wdata, busy} !== 12'd0)
      $display("FAIL reset_mem: addr=%0d we=%0d wdata=%0d busy=%0d, required all 0",
               mem_addr, mem_we, mem_wdata, busy);
    else n_pass++;
    n_checks++;
    if ({p0_held, p1_held, p0_chop_prog, p1_chop_prog} !== 20'd0)
      $display("FAIL reset_players: held=%0d/%0d prog=%0d/%0d, required 0",
               p0_held, p1_held, p0_chop_prog, p1_chop_prog);
    else n_pass++;
    $display("reset: checked outputs after reset");
  endtask

  task automatic test_carry_pickup();
    int w, start;
    bit exp_busy, exp_we;
    poke(13, 3);
    set_p(0, 208, 176, 1, 0, 0);
    run_frame(w);
    set_p(0, 208, 176, 1, 0, 1);
    start = wr_count;
    @(negedge clk_in);
    frame_tick = 1'b1;
    model_frame();
    @(negedge clk_in);
    frame_tick = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      exp_busy = (n <= 5);
      exp_we   = (n == 4);
      n_checks++;
      if (busy !== exp_busy) $display("FAIL pickup_busy_c%0d: got %0d required %0d", n, busy, exp_busy);
      else n_pass++;
      n_checks++;
      if (mem_we !== exp_we) $display("FAIL pickup_we_c%0d: got %0d required %0d", n, mem_we, exp_we);
      else n_pass++;
      if (n == 1 || n == 4) begin
        n_checks++;
        if (mem_addr !== 6'd13) $display("FAIL pickup_addr_c%0d: got %0d required 13", n, mem_addr);
        else n_pass++;
      end
      if (n == 4) begin
        n_checks++;
        if (mem_wdata !== 4'd0) $display("FAIL pickup_wdata: got %0d required 0", mem_wdata);
        else n_pass++;
      end
      @(negedge clk_in);
    end
    n_checks++;
    if (p0_held !== 4'(m_held[0])) $display("FAIL pickup_held: got %0d required %0d", p0_held, m_held[0]);
    else n_pass++;
    n_checks++;
    if (wr_count - start != m_writes) $display("FAIL pickup_writes: got %0d required %0d", wr_count - start, m_writes);
    else n_pass++;
    $display("pickup: p0 held=%0d writes=%0d", p0_held, wr_count - start);
  endtask

  task automatic test_carry_drop();
    int w;
    set_p(0, 208, 176, 1, 0, 0);
    run_frame(w);
    set_p(0, 208, 176, 1, 0, 1);
    run_frame(w);
    n_checks++;
    if (w != m_writes || ram[13] !== 4'(m_tiles[13]))
      $display("FAIL drop_write: writes=%0d tile13=%0d required writes=%0d tile13=%0d", w, ram[13], m_writes, m_tiles[13]);
    else n_pass++;
    n_checks++;
    if (p0_held !== 4'(m_held[0])) $display("FAIL drop_held: got %0d required %0d", p0_held, m_held[0]);
    else n_pass++;
    $display("drop: tile13=%0d held=%0d", ram[13], p0_held);
    run_frame(w);
    n_checks++;
    if (w != m_writes) $display("FAIL carry_level_no_req: writes=%0d required %0d", w, m_writes);
    else n_pass++;
    $display("carry held high: writes=%0d", w);
  endtask

  task automatic test_chop();
    int w;
    poke(13, 1);
    set_p(0, 208, 176, 1, 1, 0);
    for (int k = 1; k <= 30; k++) begin
      run_frame(w);
      n_checks++;
      if (p0_chop_prog !== 6'(m_prog[0]) || w != m_writes)
        $display("FAIL chop_f%0d: prog=%0d writes=%0d required prog=%0d writes=%0d", k, p0_chop_prog, w, m_prog[0], m_writes);
      else n_pass++;
      $display("chop frame %0d: prog=%0d writes=%0d", k, p0_chop_prog, w);
    end
    n_checks++;
    if (ram[13] !== 4'(m_tiles[13])) $display("FAIL chop_done_tile: got %0d required %0d", ram[13], m_tiles[13]);
    else n_pass++;
    poke(13, 1);
    for (int k = 1; k <= 10; k++) run_frame(w);
    n_checks++;
    if (p0_chop_prog !== 6'(m_prog[0])) $display("FAIL chop_mid_prog: got %0d required %0d", p0_chop_prog, m_prog[0]);
    else n_pass++;
    set_p(0, 208, 176, 1, 0, 0);
    run_frame(w);
    n_checks++;
    if (p0_chop_prog !== 6'(m_prog[0])) $display("FAIL chop_release: got %0d required %0d", p0_chop_prog, m_prog[0]);
    else n_pass++;
    $display("chop release: prog=%0d", p0_chop_prog);
  endtask

  task automatic test_both();
    int w;
    set_p(0, 208, 176, 1, 0, 0);
    set_p(1, 272, 176, 0, 0, 0);
    poke(13, 4);
    run_frame(w);
    set_p(0, 208, 176, 1, 0, 1);
    run_frame(w);
    poke(13, 5);
    set_p(1, 272, 176, 0, 0, 1);
    run_frame(w);
    for (int r = 0; r < 2; r++) begin
      set_p(0, 208, 176, 1, 0, 0);
      set_p(1, 272, 176, 0, 0, 0);
      run_frame(w);
      set_p(0, 208, 176, 1, 0, 1);
      set_p(1, 272, 176, 0, 0, 1);
      run_frame(w);
      n_checks++;
      if (ram[13] !== 4'(m_tiles[13]) || w != m_writes)
        $display("FAIL both_r%0d_tile: tile13=%0d writes=%0d required tile13=%0d writes=%0d", r, ram[13], w, m_tiles[13], m_writes);
      else n_pass++;
      n_checks++;
      if (p0_held !== 4'(m_held[0]) || p1_held !== 4'(m_held[1]))
        $display("FAIL both_r%0d_held: held=%0d/%0d required %0d/%0d", r, p0_held, p1_held, m_held[0], m_held[1]);
      else n_pass++;
      $display("both round %0d: tile13=%0d held=%0d/%0d", r, ram[13], p0_held, p1_held);
    end
  endtask

  task automatic test_edge();
    int w, start, bad;
    set_p(0, 144, 176, 0, 0, 0);
    set_p(1, 400, 300, 0, 0, 0);
    run_frame(w);
    set_p(0, 144, 176, 0, 0, 1);
    start = wr_count;
    bad = 0;
    @(negedge clk_in);
    frame_tick = 1'b1;
    model_frame();
    @(negedge clk_in);
    frame_tick = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (busy !== 1'b0) bad++;
      @(negedge clk_in);
    end
    n_checks++;
    if (bad != 0 || wr_count != start)
      $display("FAIL edge_no_access: busy cycles=%0d writes=%0d required 0/0", bad, wr_count - start);
    else n_pass++;
    $display("edge: busy cycles=%0d writes=%0d", bad, wr_count - start);
  endtask

  task automatic test_busy_tick();
    int w, start, n;
    set_p(0, 208, 176, 1, 0, 0);
    set_p(1, 208, 208, 3, 0, 0);
    poke(32, 0);
    run_frame(w);
    set_p(0, 208, 176, 1, 0, 1);
    start = wr_count;
    @(negedge clk_in);
    frame_tick = 1'b1;
    model_frame();
    @(negedge clk_in);
    frame_tick = 1'b0;
    @(negedge clk_in);
    t_carry[1] = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk_in);
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    n_checks++;
    if (busy) $display("FAIL busy_tick_timeout: busy=%0d required 0", busy);
    else n_pass++;
    @(negedge clk_in);
    n_checks++;
    if (wr_count - start != m_writes || p1_held !== 4'(m_held[1]))
      $display("FAIL busy_tick_ignored: writes=%0d p1_held=%0d required %0d/%0d", wr_count - start, p1_held, m_writes, m_held[1]);
    else n_pass++;
    run_frame(w);
    n_checks++;
    if (w != m_writes || p1_held !== 4'(m_held[1]) || ram[32] !== 4'(m_tiles[32]))
      $display("FAIL busy_tick_followup: writes=%0d p1_held=%0d tile32=%0d required %0d/%0d/%0d",
               w, p1_held, ram[32], m_writes, m_held[1], m_tiles[32]);
    else n_pass++;
    $display("busy tick: followup writes=%0d p1_held=%0d", w, p1_held);
  endtask

  task automatic test_reset_mid();
    int w, start;
    set_p(0, 208, 176, 1, 0, 0);
    set_p(1, 400, 300, 0, 0, 0);
    run_frame(w);
    set_p(0, 208, 176, 1, 0, 1);
    start = wr_count;
    @(negedge clk_in);
    frame_tick = 1'b1;
    @(negedge clk_in);
    frame_tick = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid_we: we=%0d busy=%0d required 0/0", mem_we, busy);
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, p0_held, p1_held, p0_chop_prog, p1_chop_prog} !== 30'd0)
      $display("FAIL reset_mid_outputs: addr=%0d wdata=%0d held=%0d/%0d prog=%0d/%0d required 0",
               mem_addr, mem_wdata, p0_held, p1_held, p0_chop_prog, p1_chop_prog);
    else n_pass++;
    @(negedge clk_in);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 8; n++) @(negedge clk_in);
    n_checks++;
    if (wr_count != start || ram[13] !== 4'(m_tiles[13]))
      $display("FAIL reset_mid_nowrite: writes=%0d tile13=%0d required 0/%0d", wr_count - start, ram[13], m_tiles[13]);
    else n_pass++;
    $display("reset mid-op: writes=%0d tile13=%0d", wr_count - start, ram[13]);
  endtask

  task automatic test_random();
    int w, v, bad, col, row;
    for (int a = 0; a < 50; a++) begin
      v = int'($urandom_range(0, 11));
      if (v >= 8) v = int'($urandom_range(8, 15));
      poke(a, v);
    end
    for (int i = 0; i < 2; i++) set_p(i, 208, 176, 1, 0, 0);
    for (int f = 0; f < 150; f++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          col = int'($urandom_range(0, 11)) - 1;
          row = int'($urandom_range(0, 6)) - 1;
          t_x[i]   = 9'(128 + col * 32 + int'($urandom_range(0, 31)));
          t_y[i]   = 9'(128 + row * 32 + int'($urandom_range(0, 31)));
          t_dir[i] = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 4) == 0) t_chop[i] = ~t_chop[i];
        t_carry[i] = 1'($urandom_range(0, 1));
      end
      run_frame(w);
      bad = 0;
      for (int a = 0; a < 50; a++) if (ram[a] !== 4'(m_tiles[a])) bad++;
      n_checks++;
      if (p0_held !== 4'(m_held[0]) || p1_held !== 4'(m_held[1]))
        $display("FAIL rand_f%0d_held: %0d/%0d required %0d/%0d", f, p0_held, p1_held, m_held[0], m_held[1]);
      else n_pass++;
      n_checks++;
      if (p0_chop_prog !== 6'(m_prog[0]) || p1_chop_prog !== 6'(m_prog[1]))
        $display("FAIL rand_f%0d_prog: %0d/%0d required %0d/%0d", f, p0_chop_prog, p1_chop_prog, m_prog[0], m_prog[1]);
      else n_pass++;
      n_checks++;
      if (w != m_writes || bad != 0)
        $display("FAIL rand_f%0d_mem: writes=%0d bad_tiles=%0d required writes=%0d bad_tiles=0", f, w, bad, m_writes);
      else n_pass++;
      $display("rand frame %0d: writes=%0d held=%0d/%0d prog=%0d/%0d", f, w, p0_held, p1_held, p0_chop_prog, p1_chop_prog);
    end
  endtask

  initial begin
    test_reset();
    test_carry_pickup();
    test_carry_drop();
    test_chop();
    test_both();
    test_edge();
    test_busy_tick();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
